// File: rtl/wavetable_reader_if.sv
// Bus bundle for the wavetable reader: sample-rate strobe and phase step in,
// wavetable RAM read port, interpolated sample and status flags out.
// The slave side is the reader itself; the master side drives ticks and
// owns the RAM.
interface wavetable_reader_if #(
   parameter int INPUT_BITS      = 16,
   parameter int TABLE_ADDR_BITS = 8,
   parameter int FRAC_BITS       = 16
);
   localparam int P = TABLE_ADDR_BITS + FRAC_BITS;

   logic                       tick;
   logic [P-1:0]               increment;
   logic                       rd_en;
   logic [TABLE_ADDR_BITS-1:0] rd_addr;
   logic [INPUT_BITS-1:0]      rd_data;
   logic [INPUT_BITS-1:0]      sample_out;
   logic                       sample_valid;
   logic                       busy;
   logic                       overrun;

   modport master (
      output tick,
      output increment,
      output rd_data,
      input  rd_en,
      input  rd_addr,
      input  sample_out,
      input  sample_valid,
      input  busy,
      input  overrun
   );

   modport slave (
      input  tick,
      input  increment,
      input  rd_data,
      output rd_en,
      output rd_addr,
      output sample_out,
      output sample_valid,
      output busy,
      output overrun
   );
endinterface

// File: rtl/wavetable_reader.sv
// Wavetable reader: on each accepted tick, reads two adjacent table entries
// at the current phase index and linearly interpolates between them using
// the fractional phase bits. The phase accumulator then advances by the
// increment latched with the tick.

package mypackage;
   localparam int PHASE_ACCUMULATOR_FRACTIONAL_BITS = 16;
endpackage

module wavetable_reader #(
   parameter int INPUT_BITS      = 16,
   parameter int TABLE_ADDR_BITS = 8,
   parameter int FRAC_BITS       = mypackage::PHASE_ACCUMULATOR_FRACTIONAL_BITS
) (
   input logic               clk,
   input logic               reset,
   wavetable_reader_if.slave bus
);
   localparam int P         = TABLE_ADDR_BITS + FRAC_BITS;
   // signed difference (INPUT_BITS+1) times unsigned frac (as FRAC_BITS+1 signed)
   localparam int PROD_BITS = INPUT_BITS + FRAC_BITS + 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD0,
      ST_RD1,
      ST_WAIT,
      ST_OUT
   } state_t;

   state_t                     state_reg;
   logic [P-1:0]               phase_reg;
   logic [P-1:0]               inc_reg;
   logic [TABLE_ADDR_BITS-1:0] idx_reg;
   logic [FRAC_BITS-1:0]       frac_reg;
   logic [INPUT_BITS-1:0]      s0_reg;
   logic [INPUT_BITS-1:0]      s1_reg;
   logic [INPUT_BITS-1:0]      sample_reg;
   logic                       valid_reg;
   logic                       rd_en_reg;
   logic [TABLE_ADDR_BITS-1:0] rd_addr_reg;
   logic                       busy_reg;
   logic                       overrun_reg;

   logic [INPUT_BITS-1:0]      s1_live;
   logic signed [INPUT_BITS:0] diff;
   logic [INPUT_BITS-1:0]      interp_next;

   // Interpolation from s0 and the second sample as it arrives in WAIT, so the
   // result can be registered straight into OUT. The product is shifted
   // arithmetically (floor) and the sum wraps to INPUT_BITS.
   always_comb begin
      s1_live     = (state_reg == ST_WAIT) ? bus.rd_data : s1_reg;
      diff        = $signed({1'b0, s1_live}) - $signed({1'b0, s0_reg});
      interp_next = s0_reg + INPUT_BITS'((PROD_BITS'(diff)
                      * PROD_BITS'($signed({1'b0, frac_reg}))) >>> FRAC_BITS);
   end

   // Sequencer: two RAM reads, capture both samples, present the result for
   // one cycle, then advance the phase accumulator.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         phase_reg   <= '0;
         inc_reg     <= '0;
         idx_reg     <= '0;
         frac_reg    <= '0;
         s0_reg      <= '0;
         s1_reg      <= '0;
         sample_reg  <= '0;
         valid_reg   <= 1'b0;
         rd_en_reg   <= 1'b0;
         rd_addr_reg <= '0;
         busy_reg    <= 1'b0;
         overrun_reg <= 1'b0;
      end else begin
         valid_reg <= 1'b0;

         // a tick outside IDLE is dropped but remembered until reset
         if (bus.tick && (state_reg != ST_IDLE)) begin
            overrun_reg <= 1'b1;
         end

         case (state_reg)
            ST_IDLE: begin
               if (bus.tick) begin
                  idx_reg     <= phase_reg[P-1:FRAC_BITS];
                  frac_reg    <= phase_reg[FRAC_BITS-1:0];
                  inc_reg     <= bus.increment;
                  rd_en_reg   <= 1'b1;
                  rd_addr_reg <= phase_reg[P-1:FRAC_BITS];
                  busy_reg    <= 1'b1;
                  state_reg   <= ST_RD0;
               end
            end
            ST_RD0: begin
               // next table entry, wrapping at the end of the table
               rd_addr_reg <= idx_reg + TABLE_ADDR_BITS'(1);
               state_reg   <= ST_RD1;
            end
            ST_RD1: begin
               s0_reg    <= bus.rd_data;
               rd_en_reg <= 1'b0;
               state_reg <= ST_WAIT;
            end
            ST_WAIT: begin
               s1_reg     <= bus.rd_data;
               sample_reg <= interp_next;
               valid_reg  <= 1'b1;
               state_reg  <= ST_OUT;
            end
            ST_OUT: begin
               phase_reg <= phase_reg + inc_reg;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               rd_en_reg <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.rd_en        = rd_en_reg;
   assign bus.rd_addr      = rd_addr_reg;
   assign bus.sample_out   = sample_reg;
   assign bus.sample_valid = valid_reg;
   assign bus.busy         = busy_reg;
   assign bus.overrun      = overrun_reg;

endmodule

// File: tb/tb_wavetable_reader.sv
// Bench for wavetable_reader: behavioural RAM, arithmetic reference model of
// linear interpolation over the phase accumulator, directed corner cases and
// randomized tables/increments.
module tb_wavetable_reader;
   localparam int IW = 16;
   localparam int AW = 8;
   localparam int F  = mypackage::PHASE_ACCUMULATOR_FRACTIONAL_BITS;
   localparam int P  = AW + F;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   wavetable_reader_if #(.INPUT_BITS(IW), .TABLE_ADDR_BITS(AW), .FRAC_BITS(F)) bus();

   wavetable_reader #(.INPUT_BITS(IW), .TABLE_ADDR_BITS(AW), .FRAC_BITS(F)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [IW-1:0] ram [256];
   int            n_checks = 0;
   int            n_fail   = 0;
   longint        ref_phase;

   always #5 clk = ~clk;

   // RAM with one-cycle registered read
   always @(posedge clk) begin
      if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];
   end

   // Expected sample: s0 + floor((s1 - s0) * frac / 2^F), wrapped to IW bits
   function automatic logic [IW-1:0] model_sample(input longint ph);
      longint den, idx, fr, s0, s1, num, q;
      den = longint'(1) << F;
      idx = ph / den;
      fr  = ph % den;
      s0  = longint'(ram[int'(idx)]);
      s1  = longint'(ram[int'((idx + 1) % 256)]);
      num = (s1 - s0) * fr;
      q   = num / den;
      if (num < 0 && (num % den) != 0) q = q - 1;
      return IW'(s0 + q);
   endfunction

   task automatic fill_ramp();
      for (int i = 0; i < 256; i++) ram[i] = IW'(i * 256);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset    = 1'b1;
      bus.tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset     = 1'b0;
      ref_phase = 0;
   endtask

   // One tick; records both read addresses, rd_en in C1..C4, first valid cycle
   task automatic sample_cycle(input logic [P-1:0] inc, output logic [AW-1:0] a0,
                               output logic [AW-1:0] a1, output logic [3:0] en,
                               output int lat, output int nvalid, output logic [IW-1:0] out);
      @(negedge clk);
      bus.tick      = 1'b1;
      bus.increment = inc;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      a0 = '0; a1 = '0; en = '0; lat = -1; nvalid = 0; out = '0;
      for (int c = 1; c <= 8; c++) begin
         if (c == 1) a0 = bus.rd_addr;
         if (c == 2) a1 = bus.rd_addr;
         if (c <= 4) en[c-1] = bus.rd_en;
         if (bus.sample_valid) begin
            nvalid++;
            if (lat < 0) begin
               lat = c;
               out = bus.sample_out;
            end
         end
         @(posedge clk);
         #1;
      end
      $display("txn inc=%h addr=%0d/%0d rd_en=%b lat=%0d valids=%0d sample=%h",
               inc, a0, a1, en, lat, nvalid, out);
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_checks++;
      if (bus.sample_out !== '0 || bus.sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_sample: got out=%h valid=%b, required 0/0", bus.sample_out, bus.sample_valid);
      end
      n_checks++;
      if (bus.rd_en !== 1'b0 || bus.rd_addr !== '0) begin
         n_fail++;
         $display("FAIL reset_rd: got rd_en=%b rd_addr=%h, required 0/0", bus.rd_en, bus.rd_addr);
      end
      n_checks++;
      if (bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_flags: got busy=%b overrun=%b, required 0/0", bus.busy, bus.overrun);
      end
      // reset wins over a simultaneous tick
      bus.tick      = 1'b1;
      bus.increment = P'(1) << F;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_vs_tick: got busy=%b rd_en=%b, required 0/0", bus.busy, bus.rd_en);
      end
      bus.tick = 1'b0;
      do_reset();
   endtask

   task automatic test_ramp();
      logic [AW-1:0] a0, a1;
      logic [3:0]    en;
      int            lat, nv;
      logic [IW-1:0] out;
      logic [IW-1:0] exp_s [3];
      exp_s = '{16'h0000, 16'h0100, 16'h0200};
      fill_ramp();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         sample_cycle(P'(1) << F, a0, a1, en, lat, nv, out);
         n_checks++;
         if (out !== exp_s[k]) begin
            n_fail++;
            $display("FAIL ramp_sample[%0d]: got %h, required %h", k, out, exp_s[k]);
         end
         n_checks++;
         if (lat != 4 || nv != 1) begin
            n_fail++;
            $display("FAIL ramp_latency[%0d]: got lat=%0d valids=%0d, required 4/1", k, lat, nv);
         end
         n_checks++;
         if (a0 !== AW'(k) || a1 !== AW'(k + 1) || en !== 4'b0011) begin
            n_fail++;
            $display("FAIL ramp_reads[%0d]: got %0d/%0d en=%b, required %0d/%0d en=0011",
                     k, a0, a1, en, k, k + 1);
         end
      end
   endtask

   task automatic test_half_step();
      logic [AW-1:0] a0, a1;
      logic [3:0]    en;
      int            lat, nv;
      logic [IW-1:0] out;
      logic [IW-1:0] exp_s [4];
      exp_s = '{16'h0000, 16'h0080, 16'h0100, 16'h0180};
      fill_ramp();
      do_reset();
      for (int k = 0; k < 4; k++) begin
         sample_cycle(P'(1) << (F - 1), a0, a1, en, lat, nv, out);
         n_checks++;
         if (out !== exp_s[k] || lat != 4) begin
            n_fail++;
            $display("FAIL half_sample[%0d]: got %h lat=%0d, required %h lat=4", k, out, lat, exp_s[k]);
         end
         n_checks++;
         if (a0 !== AW'(k / 2)) begin
            n_fail++;
            $display("FAIL half_addr[%0d]: got %0d, required %0d", k, a0, k / 2);
         end
      end
   endtask

   task automatic test_wrap();
      logic [AW-1:0] a0, a1;
      logic [3:0]    en;
      int            lat, nv;
      logic [IW-1:0] out;
      fill_ramp();
      do_reset();
      sample_cycle((P'(255) << F) | (P'(1) << (F - 1)), a0, a1, en, lat, nv, out);
      sample_cycle('0, a0, a1, en, lat, nv, out);
      n_checks++;
      if (a0 !== 8'd255 || a1 !== 8'd0) begin
         n_fail++;
         $display("FAIL wrap_addr: got %0d/%0d, required 255/0", a0, a1);
      end
      n_checks++;
      if (out !== 16'h7F80) begin
         n_fail++;
         $display("FAIL wrap_sample: got %h, required 7f80", out);
      end
   endtask

   task automatic test_extremes();
      logic [AW-1:0] a0, a1;
      logic [3:0]    en;
      int            lat, nv;
      logic [IW-1:0] out;
      logic [IW-1:0] exp_s [2];
      exp_s = '{16'hFEFF, 16'h00FF};
      for (int c = 0; c < 2; c++) begin
         fill_ramp();
         ram[10] = (c == 0) ? 16'hFFFF : 16'h0000;
         ram[11] = (c == 0) ? 16'h0000 : 16'hFFFF;
         do_reset();
         sample_cycle((P'(10) << F) | (P'(1) << (F - 8)), a0, a1, en, lat, nv, out);
         sample_cycle('0, a0, a1, en, lat, nv, out);
         n_checks++;
         if (out !== exp_s[c] || a0 !== 8'd10) begin
            n_fail++;
            $display("FAIL extreme_sample[%0d]: got %h at addr %0d, required %h at addr 10",
                     c, out, a0, exp_s[c]);
         end
      end
      fill_ramp();
   endtask

   task automatic test_random();
      logic [AW-1:0] a0, a1;
      logic [3:0]    en;
      int            lat, nv;
      logic [IW-1:0] out, exp_out;
      logic [P-1:0]  inc;
      for (int i = 0; i < 256; i++) ram[i] = IW'($urandom);
      do_reset();
      for (int k = 0; k < 24; k++) begin
         if (k % 3 == 0) inc = P'($urandom_range(0, 3 << F));
         else            inc = P'($urandom);
         exp_out = model_sample(ref_phase);
         sample_cycle(inc, a0, a1, en, lat, nv, out);
         n_checks++;
         if (out !== exp_out || lat != 4 || nv != 1) begin
            n_fail++;
            $display("FAIL random_sample[%0d]: got %h lat=%0d valids=%0d, required %h lat=4 valids=1",
                     k, out, lat, nv, exp_out);
         end
         n_checks++;
         if (a0 !== AW'(ref_phase >> F) || a1 !== AW'((ref_phase >> F) + 1)) begin
            n_fail++;
            $display("FAIL random_addr[%0d]: got %0d/%0d, required %0d/%0d", k, a0, a1,
                     AW'(ref_phase >> F), AW'((ref_phase >> F) + 1));
         end
         ref_phase = (ref_phase + longint'(inc)) % (longint'(1) << P);
      end
      n_checks++;
      if (bus.overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL random_overrun: got %b, required 0", bus.overrun);
      end
      fill_ramp();
   endtask

   task automatic test_overrun();
      logic [AW-1:0] a0, a1;
      logic [3:0]    en;
      int            lat, nv;
      logic [IW-1:0] out;
      fill_ramp();
      do_reset();
      @(negedge clk);
      bus.tick      = 1'b1;
      bus.increment = P'(3) << F;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      @(negedge clk);
      @(negedge clk);
      // second tick two cycles later, with a different step that must be dropped
      bus.tick      = 1'b1;
      bus.increment = P'(7) << F;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      nv = 0;
      for (int c = 0; c < 10; c++) begin
         if (bus.sample_valid) nv++;
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (nv != 1 || bus.overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_single: got valids=%0d overrun=%b, required 1/1", nv, bus.overrun);
      end
      sample_cycle('0, a0, a1, en, lat, nv, out);
      n_checks++;
      if (a0 !== 8'd3 || out !== 16'h0300) begin
         n_fail++;
         $display("FAIL overrun_phase: got addr %0d sample %h, required 3/0300", a0, out);
      end
      n_checks++;
      if (bus.overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL overrun_sticky: got %b, required 1", bus.overrun);
      end
      do_reset();
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clear: got %b, required 0", bus.overrun);
      end
      // a tick landing in OUT is ignored as well
      @(negedge clk);
      bus.tick      = 1'b1;
      bus.increment = '0;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (bus.sample_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL out_valid: got %b, required 1", bus.sample_valid);
      end
      @(negedge clk);
      bus.tick = 1'b1;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.overrun !== 1'b1) begin
         n_fail++;
         $display("FAIL out_tick: got busy=%b rd_en=%b overrun=%b, required 0/0/1",
                  bus.busy, bus.rd_en, bus.overrun);
      end
      do_reset();
   endtask

   task automatic test_reset_abort();
      logic [AW-1:0] a0, a1;
      logic [3:0]    en;
      int            lat, nv;
      logic [IW-1:0] out;
      fill_ramp();
      do_reset();
      sample_cycle(P'(5) << F, a0, a1, en, lat, nv, out);
      @(negedge clk);
      bus.tick      = 1'b1;
      bus.increment = '0;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.rd_en !== 1'b1 || bus.rd_addr !== 8'd6) begin
         n_fail++;
         $display("FAIL abort_rd1: got rd_en=%b rd_addr=%0d, required 1/6", bus.rd_en, bus.rd_addr);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.rd_en !== 1'b0 || bus.sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_state: got busy=%b rd_en=%b valid=%b, required 0/0/0",
                  bus.busy, bus.rd_en, bus.sample_valid);
      end
      @(negedge clk);
      reset = 1'b0;
      nv = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk);
         #1;
         if (bus.sample_valid) nv++;
      end
      n_checks++;
      if (nv != 0) begin
         n_fail++;
         $display("FAIL abort_novalid: got %0d valids, required 0", nv);
      end
      sample_cycle('0, a0, a1, en, lat, nv, out);
      n_checks++;
      if (a0 !== 8'd0 || out !== 16'h0000) begin
         n_fail++;
         $display("FAIL abort_restart: got addr %0d sample %h, required 0/0000", a0, out);
      end
   endtask

   initial begin
      bus.tick      = 1'b0;
      bus.increment = '0;
      ref_phase     = 0;
      fill_ramp();
      repeat (3) @(posedge clk);
      test_reset();
      test_ramp();
      test_half_step();
      test_wrap();
      test_extremes();
      test_random();
      test_overrun();
      test_reset_abort();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/wavetable_reader.md
WAVETABLE_READER -- requirements
Module: wavetable_reader

Interface
Parameters:
REQ-001 SHALL have INPUT_BITS, default 16, sample width in bits (unsigned samples).
REQ-002 SHALL have TABLE_ADDR_BITS, default 8, wavetable index width (table depth 2^TABLE_ADDR_BITS).
REQ-003 SHALL have FRAC_BITS, default mypackage::PHASE_ACCUMULATOR_FRACTIONAL_BITS, phase fractional width.

Ports (P = TABLE_ADDR_BITS+FRAC_BITS):
REQ-004 SHALL have clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have tick  input  1  single-cycle sample-rate strobe requesting one output sample.
REQ-007 SHALL have increment  input  P  phase step per sample, unsigned, sampled at accepted tick.
REQ-008 SHALL have rd_en  output  1  wavetable RAM read enable.
REQ-009 SHALL have rd_addr  output  TABLE_ADDR_BITS  wavetable RAM read address.
REQ-010 SHALL have rd_data  input  INPUT_BITS  RAM read data, valid exactly one cycle after rd_en.
REQ-011 SHALL have sample_out  output  INPUT_BITS  interpolated sample, held until next result.
REQ-012 SHALL have sample_valid  output  1  one-cycle pulse marking a new sample_out.
REQ-013 SHALL have busy  output  1  high in every non-IDLE state.
REQ-014 SHALL have overrun  output  1  sticky flag: tick arrived while busy.

Function
REQ-015 SHALL hold a P-bit phase register; idx = phase[P-1:FRAC_BITS], frac = phase[FRAC_BITS-1:0].
REQ-016 SHALL implement states IDLE -> RD0 -> RD1 -> WAIT -> OUT -> IDLE, one cycle each after IDLE.
REQ-017 SHALL leave IDLE only on tick=1, latching phase-derived idx/frac and increment that cycle.
REQ-018 RD0: rd_en=1, rd_addr=idx.
REQ-019 RD1: rd_en=1, rd_addr=(idx+1) mod 2^TABLE_ADDR_BITS; capture rd_data as s0.
REQ-020 WAIT: rd_en=0; capture rd_data as s1.
REQ-021 OUT: sample_valid=1; sample_out = s0 + ((s1 - s0) * frac) >>> FRAC_BITS, difference signed INPUT_BITS+1, arithmetic shift (floor), result truncated to INPUT_BITS.
REQ-022 SHALL register the REQ-021 result so sample_out and sample_valid appear together in OUT.
REQ-023 SHALL update phase = (phase + latched increment) mod 2^P at the end of OUT; wrap silent.
REQ-024 Latency: tick accepted in cycle C0 -> sample_valid=1 in cycle C4; max one sample per 5 cycles.
REQ-025 tick while busy SHALL be ignored (no state/phase change) and SHALL set overrun; tick in OUT also ignored.
REQ-026 overrun SHALL clear only on reset.
REQ-027 rd_en SHALL be 0 and rd_addr SHALL hold its last value in IDLE, WAIT and OUT.
REQ-028 frac=0 SHALL give sample_out=s0 exactly; s1 never appears unweighted.

Reset
REQ-029 reset SHALL force state IDLE, phase=0, sample_out=0, sample_valid=0, rd_en=0, rd_addr=0, busy=0, overrun=0, s0=s1=0.
REQ-030 reset asserted in any state SHALL abort the sample in progress; no sample_valid for it.
REQ-031 reset SHALL dominate tick in the same cycle.

Verification
REQ-032 RAM model table[i]=i*256, increment=1<<FRAC_BITS, 3 ticks spaced 8 cycles -> sample_out 0x0000, 0x0100, 0x0200, each valid 4 cycles after tick.
REQ-033 increment=1<<(FRAC_BITS-1), same table -> sample_out 0x0000, 0x0080, 0x0100, 0x0180.
REQ-034 Wrap: phase idx=255, frac=half, table[255]=0xFF00, table[0]=0 -> rd_addr 255 then 0, sample_out=0x7F80.
REQ-035 table[k]=0xFFFF, table[k+1]=0, frac=1<<(FRAC_BITS-8) -> sample_out=0xFEFF; table[k]=0, table[k+1]=0xFFFF, same frac -> 0x00FF.
REQ-036 Second tick 2 cycles after first -> only one sample_valid, overrun=1 and stays 1 until reset.
REQ-037 reset asserted in RD1 -> next cycle busy=0, rd_en=0, no sample_valid; following tick reads rd_addr 0.
